// File: rtl/multicore_pkg.sv
// Shared constants and FSM encoding for the multi-core result arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package multicore_pkg;

  localparam int NUM_CORES = 61;
  localparam int DATA_W    = 32;
  localparam int IDX_W     = 6;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    COLLECT,
    DONE
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first eligible core at or after rr_ptr, modulo NUM_CORES.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_picker #(
  parameter int NUM_CORES = 61,
  parameter int IDX_W     = 6
) (
  input  logic [NUM_CORES-1:0] elig,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [2*NUM_CORES-1:0] dbl;
  logic [NUM_CORES-1:0]   rot;
  logic [IDX_W-1:0]       off;
  logic [IDX_W:0]         sum;

  // Doubling the vector turns the rotate into a plain shift; bit 0 of rot is core rr_ptr.
  assign dbl = {elig, elig};
  assign rot = NUM_CORES'(dbl >> rr_ptr);

  // Priority-encode the rotated vector, then map the offset back to a core index.
  always_comb begin
    grant_valid = 1'b0;
    off         = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_valid = 1'b1;
        off         = IDX_W'(i);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(NUM_CORES)) begin
      sum = sum - (IDX_W+1)'(NUM_CORES);
    end
    grant_idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/multicore_result_arbiter.sv
// Staggers core reset release, then serializes per-core results round-robin and tracks the minimum.
// Latency: a core eligible before an edge is presented on out_valid right after that edge.
// Backpressure: out_data/out_index hold while out_valid & !out_ready; one result per cycle when ready.
module multicore_result_arbiter #(
  parameter int NUM_CORES = multicore_pkg::NUM_CORES,
  parameter int DATA_W    = multicore_pkg::DATA_W,
  parameter int IDX_W     = multicore_pkg::IDX_W
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        start,
  output logic [NUM_CORES-1:0]        core_reset,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES*DATA_W-1:0] core_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_index,
  output logic [DATA_W-1:0]           best_result,
  output logic [IDX_W-1:0]            best_index,
  output logic                        busy,
  output logic                        all_done
);

  import multicore_pkg::*;

  state_t               state_q, state_d;
  logic [NUM_CORES-1:0] core_reset_q;
  logic [NUM_CORES-1:0] collected;
  logic [IDX_W-1:0]     lc;
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_CORES-1:0] elig;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic [DATA_W-1:0]    grant_data;
  logic                 active;
  logic                 launch_go;
  logic                 launch_last;
  logic                 capture;
  logic                 handshake;

  // Collection runs during LAUNCH too, so early finishers are drained while others are still held.
  assign active      = (state_q == LAUNCH) || (state_q == COLLECT);
  assign launch_go   = start && ((state_q == IDLE) || (state_q == DONE));
  assign launch_last = (lc == IDX_W'(NUM_CORES - 1));
  assign elig        = active ? (core_done & ~core_reset_q & ~collected) : '0;
  assign handshake   = out_valid & out_ready;
  assign capture     = grant_valid & (~out_valid | out_ready);
  assign grant_data  = core_result[grant_idx*DATA_W +: DATA_W];

  rr_picker #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_picker (
    .elig        (elig),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: DONE is reached only once every core is collected and the output slot drains.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LAUNCH;
      LAUNCH:  if (launch_last) state_d = COLLECT;
      COLLECT: if ((&collected) && (!out_valid || handshake)) state_d = DONE;
      DONE:    if (start) state_d = LAUNCH;
      default: state_d = IDLE;
    endcase
  end

  // Launch counter, per-core resets, collected mask and round-robin pointer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      core_reset_q <= '1;
      collected    <= '0;
      lc           <= '0;
      rr_ptr       <= '0;
    end else begin
      if (launch_go) begin
        core_reset_q <= '1;
        collected    <= '0;
        lc           <= '0;
      end else if (state_q == LAUNCH) begin
        core_reset_q[lc] <= 1'b0;
        lc               <= launch_last ? '0 : lc + 1'b1;
      end
      if (capture) begin
        collected[grant_idx] <= 1'b1;
        rr_ptr <= (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Output register and running minimum; ties keep the earlier capture (strict compare).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
      best_result <= '1;
      best_index  <= '0;
    end else begin
      if (launch_go) begin
        best_result <= '1;
        best_index  <= '0;
      end
      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_index <= grant_idx;
        if (grant_data < best_result) begin
          best_result <= grant_data;
          best_index  <= grant_idx;
        end
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign core_reset = core_reset_q;
  assign busy       = active;
  assign all_done   = (state_q == DONE);

endmodule

// File: tb/tb_multicore_result_arbiter.sv
// Randomized and directed bench for multicore_result_arbiter against a cycle-level reference model.
// Latency: n/a.
// Backpressure: out_ready is driven both held-high and randomly toggled.
module tb_multicore_result_arbiter;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int IW = 3;

  logic              Clk;
  logic              Reset;
  logic              start;
  logic [NC-1:0]     core_reset;
  logic [NC-1:0]     core_done;
  logic [NC*DW-1:0]  core_result;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_index;
  logic [DW-1:0]     best_result;
  logic [IW-1:0]     best_index;
  logic              busy;
  logic              all_done;

  multicore_result_arbiter #(.NUM_CORES(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .core_reset  (core_reset),
    .core_done   (core_done),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .best_result (best_result),
    .best_index  (best_index),
    .busy        (busy),
    .all_done    (all_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int got_cnt [8];

  // Reference model: phase 0 idle, 1 launch, 2 collect, 3 done; m_rel = cores released so far.
  int          m_phase = 0;
  int          m_rel   = 0;
  int          m_ptr   = 0;
  bit          m_got [NC];
  bit          m_vld   = 1'b0;
  logic [31:0] m_dat   = '0;
  int          m_idx   = 0;
  logic [31:0] m_best  = 32'hFFFF_FFFF;
  int          m_bidx  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_step();
    bit hs, cap, all_got, go;
    int g, c;
    if (Reset) begin
      m_phase = 0; m_rel = 0; m_ptr = 0; m_vld = 1'b0; m_dat = '0; m_idx = 0;
      m_best = 32'hFFFF_FFFF; m_bidx = 0;
      for (int i = 0; i < NC; i++) m_got[i] = 1'b0;
      return;
    end
    hs = m_vld && out_ready;
    g  = -1;
    if (m_phase == 1 || m_phase == 2) begin
      for (int k = 0; k < NC; k++) begin
        c = (m_ptr + k) % NC;
        if (g < 0 && core_done[c] && c < m_rel && !m_got[c]) g = c;
      end
    end
    cap = (g >= 0) && (!m_vld || out_ready);
    all_got = 1'b1;
    for (int i = 0; i < NC; i++) if (!m_got[i]) all_got = 1'b0;
    go = start && (m_phase == 0 || m_phase == 3);
    if (go) begin
      m_phase = 1; m_rel = 0; m_best = 32'hFFFF_FFFF; m_bidx = 0;
      for (int i = 0; i < NC; i++) m_got[i] = 1'b0;
    end else if (m_phase == 1) begin
      m_rel++;
      if (m_rel == NC) m_phase = 2;
    end else if (m_phase == 2 && all_got && (!m_vld || hs)) begin
      m_phase = 3;
    end
    if (cap) begin
      m_got[g] = 1'b1;
      m_ptr    = (g + 1) % NC;
      m_vld    = 1'b1;
      m_dat    = core_result[g*DW +: DW];
      m_idx    = g;
      if (m_dat < m_best) begin
        m_best = m_dat;
        m_bidx = g;
      end
    end else if (hs) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [NC-1:0] exp_cr;
    for (int k = 0; k < NC; k++) exp_cr[k] = (k >= m_rel);
    check("core_reset",  64'(core_reset),  64'(exp_cr));
    check("out_valid",   64'(out_valid),   64'(m_vld));
    check("out_data",    64'(out_data),    64'(m_dat));
    check("out_index",   64'(out_index),   64'(m_idx));
    check("best_result", 64'(best_result), 64'(m_best));
    check("best_index",  64'(best_index),  64'(m_bidx));
    check("busy",        64'(busy),        64'(m_phase == 1 || m_phase == 2));
    check("all_done",    64'(all_done),    64'(m_phase == 3));
  endtask

  task automatic cycle();
    if (!Reset && out_valid && out_ready) got_cnt[out_index]++;
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_start();
    for (int i = 0; i < 8; i++) got_cnt[i] = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input bit rnd);
    int n;
    n = 0;
    while (m_phase != 3 && n < budget) begin
      if (rnd) begin
        for (int i = 0; i < NC; i++) if ($urandom_range(0, 3) == 0) core_done[i] = 1'b1;
        out_ready = ($urandom_range(0, 2) != 0);
        start     = ($urandom_range(0, 15) == 0);
      end
      cycle();
      n++;
    end
    start = 1'b0;
    check("run_done", 64'(all_done), 64'(1));
    for (int i = 0; i < NC; i++) check("once_per_core", 64'(got_cnt[i]), 64'(1));
  endtask

  task automatic set_results(input logic [31:0] r0, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] r3);
    core_result = {r3, r2, r1, r0};
  endtask

  initial begin
    int hs_total;
    int n;
    Reset = 1'b1; start = 1'b0; core_done = '0; out_ready = 1'b0; core_result = '0;
    for (int i = 0; i < NC; i++) m_got[i] = 1'b0;
    for (int i = 0; i < 8; i++) got_cnt[i] = 0;

    // Reset state.
    cycle();
    cycle();
    check("rst_core_reset", 64'(core_reset), 64'(4'hF));
    check("rst_out_valid",  64'(out_valid),  64'(0));
    check("rst_best",       64'(best_result), 64'(32'hFFFF_FFFF));
    check("rst_busy",       64'(busy),       64'(0));
    Reset = 1'b0;
    cycle();

    // Staggered launch, then simultaneous done; results {7,3,3,9}.
    set_results(32'd7, 32'd3, 32'd3, 32'd9);
    out_ready = 1'b1;
    do_start();
    for (int k = 1; k <= NC; k++) begin
      cycle();
      check("launch_core_reset", 64'(core_reset), 64'(4'(4'hF << k)));
      check("launch_busy",       64'(busy),       64'(1));
    end
    core_done = 4'hF;
    for (int k = 0; k < NC; k++) begin
      cycle();
      check("simul_valid", 64'(out_valid), 64'(1));
      check("simul_idx",   64'(out_index), 64'(k));
    end
    cycle();
    check("simul_all_done", 64'(all_done),    64'(1));
    check("best_value",     64'(best_result), 64'(3));
    check("best_idx",       64'(best_index),  64'(1));
    for (int i = 0; i < NC; i++) check("simul_once", 64'(got_cnt[i]), 64'(1));

    // Backpressure: restart from DONE with done already high, stall 3 cycles on first result.
    set_results(32'd20, 32'd5, 32'd11, 32'd5);
    do_start();
    n = 0;
    while (!out_valid && n < 20) begin cycle(); n++; end
    check("bp_pending", 64'(out_valid), 64'(1));
    out_ready = 1'b0;
    repeat (3) cycle();
    check("bp_hold_idx",  64'(out_index), 64'(0));
    check("bp_hold_data", 64'(out_data),  64'(20));
    out_ready = 1'b1;
    run_to_done(50, 1'b0);
    check("bp_best_idx", 64'(best_index), 64'(1));

    // Reset mid-collect after 2 results, then recollect all.
    core_done = '0;
    do_start();
    core_done = 4'hF;
    n = 0;
    hs_total = 0;
    while (hs_total < 2 && n < 50) begin
      cycle();
      n++;
      hs_total = got_cnt[0] + got_cnt[1] + got_cnt[2] + got_cnt[3];
    end
    check("mid_hs", 64'(hs_total), 64'(2));
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    check("mid_core_reset", 64'(core_reset),  64'(4'hF));
    check("mid_out_valid",  64'(out_valid),   64'(0));
    check("mid_out_index",  64'(out_index),   64'(0));
    check("mid_best",       64'(best_result), 64'(32'hFFFF_FFFF));
    check("mid_busy",       64'(busy),        64'(0));
    do_start();
    run_to_done(50, 1'b0);

    // Randomized runs: staggered done arrivals, random ready, stray start pulses.
    for (int r = 0; r < 12; r++) begin
      core_done = '0;
      set_results(32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
                  32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)));
      do_start();
      run_to_done(300, 1'b1);
      out_ready = 1'b1;
      repeat ($urandom_range(0, 3)) cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicore_result_arbiter.md
# multicore_result_arbiter

Sequencer and result collector for the multi-core processor array. It releases the per-core resets in a staggered launch and watches each core's done flag. It serializes the cores' `$v0` results through one valid/ready port in round-robin order and tracks the minimum result and its core index. It sits between the core array and the board-level result/readout logic.

## Interface
- `NUM_CORES`, default 61: number of processor cores (≥2).
- `DATA_W`, default 32: result width.
- `IDX_W`, default 6: core index width, ≥ clog2(NUM_CORES).

- `Clk` in 1: single clock, all logic on rising edge.
- `Reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle run request; honoured only in IDLE or DONE.
- `core_reset` out NUM_CORES: per-core reset, one bit per core.
- `core_done` in NUM_CORES: level; core i has finished.
- `core_result` in NUM_CORES*DATA_W: core i result at `[i*DATA_W +: DATA_W]`.
- `out_valid` out 1: `out_data`/`out_index` hold a result.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out DATA_W: result word.
- `out_index` out IDX_W: source core index.
- `best_result` out DATA_W: running unsigned minimum.
- `best_index` out IDX_W: core index of `best_result`.
- `busy` out 1: the block is in LAUNCH or COLLECT.
- `all_done` out 1: the block is in DONE.

## Operation
- The state machine has four states: IDLE, LAUNCH, COLLECT and DONE.
- **IDLE:** all `core_reset` bits are 1. On `start`, go to LAUNCH, clear the `collected` mask, set `best_result` to all-ones and `best_index` to 0.
- **LAUNCH:**
  - Launch counter `lc` starts at 0.
  - Each cycle clears `core_reset[lc]` and increments `lc`.
  - After clearing bit NUM_CORES-1, go to COLLECT.
- **COLLECT:**
  - When `collected` is all ones and `out_valid` is 0 (or a handshake completes this cycle), go to DONE.
- **DONE:**
  - Cores stay out of reset.
  - `best_*` stay stable.
  - On `start`, all `core_reset` bits go to 1 and the block re-enters LAUNCH on the same edge, with the same clears as the IDLE→LAUNCH transition.
- **`start` handling:** `start` is ignored in LAUNCH and COLLECT.
- **Eligibility:** core i is eligible when `core_done[i] & ~core_reset[i] & ~collected[i]`. Collection is active in both LAUNCH and COLLECT.
- **Round-robin selection:**
  - Select the first eligible index at or after `rr_ptr`, searching modulo NUM_CORES.
  - After a grant g, `rr_ptr` becomes g+1, wrapping from NUM_CORES-1 to 0.
  - `rr_ptr` resets to 0.
- **Capture:**
  - Capture happens when an eligible core exists and (`!out_valid || out_ready`).
  - On capture, register the result and index, set `out_valid`, and set `collected[g]`.
  - When a handshake completes with nothing eligible, `out_valid` clears.
- **Best tracking:**
  - On capture, if the result is strictly less than `best_result` (unsigned), update `best_result` and `best_index`.
  - Ties keep the earlier capture.
- **Reset mid-operation:** any state goes to IDLE. All outputs take their reset values and `collected` and `lc` are cleared.

## Timing
- **Reset values:**
  - `core_reset` all ones.
  - `out_valid`, `busy`, `all_done` = 0.
  - `out_data`, `out_index`, `best_index` = 0.
  - `best_result` all ones.
- **Launch timing:** with `start` sampled at edge t, `core_reset[k]` is low after edge t+1+k, and COLLECT is entered at edge t+NUM_CORES.
- **Capture latency:** a core that becomes eligible before edge e, and is selected at e, shows `out_valid` after edge e.
- **Throughput:** one result per cycle when `out_ready` is held high.
- **Backpressure:** `out_data`/`out_index` must not change while `out_valid & !out_ready`.
- **Best outputs:** `best_*` update on the same edge as capture.
- **DONE entry:** `all_done` asserts the cycle after the last handshake.
- **Simultaneous `core_done` edges:** resolved purely by `rr_ptr`; no result is dropped or duplicated.

## Structure
- **Package `multicore_pkg`:**
  - `NUM_CORES`, `DATA_W`, `IDX_W` constants.
  - State enum `{IDLE, LAUNCH, COLLECT, DONE}`.
- **Sub-module `rr_picker`:**
  - Combinational; inputs are the eligibility vector and `rr_ptr`.
  - Outputs are `grant_valid` and `grant_idx`.
  - Implemented as a rotate plus priority-encode.
- **Top block:** the FSM, launch counter, output register and best tracker.

## Test plan
- **Reset state:** assert `Reset` 2 cycles → `core_reset`=all ones, `out_valid`=0, `best_result`=0xFFFFFFFF, `busy`=0.
- **Staggered launch:** NUM_CORES=4, `start` at edge 0 → `core_reset` = 1110, 1100, 1000, 0000 after edges 1–4; `busy`=1 during those cycles.
- **Simultaneous done:** NUM_CORES=4, all `core_done` rise together, `out_ready`=1 → indices 0,1,2,3 on 4 consecutive cycles, then `all_done`=1.
- **Backpressure:** `out_ready`=0 for 3 cycles during a pending result → `out_data`/`out_index` stable; the next result appears only after the handshake.
- **Best tracking:** results {7,3,3,9} → `best_result`=3, `best_index`=1.
- **Reset mid-collect:** assert `Reset` after 2 of 4 results → IDLE with all reset values. A new `start` recollects all 4 results with no duplicates.
